// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 pipeline fetch stage.
//   RESET_PC_DEF  - default PC loaded on reset
//   NOP_INSTR_DEF - default instruction word used for IF/ID bubbles
//   PC_INC        - sequential fetch increment (one 32-bit instruction)
//   fetch_state_e - fetch-stage state: FILL, RUN, STALL, FLUSHED
//   fetch_next_state - next-state function shared by the fetch stage
package legv8_pkg;

  localparam logic [63:0] RESET_PC_DEF  = 64'h0;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [63:0] PC_INC        = 64'd4;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    RUN     = 2'd1,
    STALL   = 2'd2,
    FLUSHED = 2'd3
  } fetch_state_e;

  // Flush always wins, then advance. Any other edge is a stall of some
  // kind; FILL is the only state that waits in place through a stall.
  function automatic fetch_state_e fetch_next_state(
    input fetch_state_e cur,
    input logic         flush,
    input logic         advance
  );
    if (flush)             return FLUSHED;
    else if (advance)      return RUN;
    else if (cur == FILL)  return FILL;
    else                   return STALL;
  endfunction

endpackage

// File: rtl/fetch_stall_stage_stall_monitor.sv
// Stall bookkeeping for the fetch stage.
//   i_clk, i_reset   - clock and asynchronous active-high reset
//   i_pc_write       - PC may advance
//   i_if_id_write    - IF/ID may load
//   i_branch_taken   - redirect/flush; overrides the stall handshake
//   o_stall_count    - saturating count of stall cycles since reset
//   o_stall_timeout  - sticky, set when a consecutive stall run hits MAX_STALL
//   o_protocol_error - sticky, set on PCWrite=1 with IF_ID_Write=0
module stall_monitor
  import legv8_pkg::*;
#(
  parameter int MAX_STALL = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_write,
  input  logic        i_if_id_write,
  input  logic        i_branch_taken,
  output logic [31:0] o_stall_count,
  output logic        o_stall_timeout,
  output logic        o_protocol_error
);

  localparam logic [7:0] RUN_MAX = 8'(MAX_STALL);

  logic [31:0] r_stall_count;
  logic [7:0]  r_run;
  logic        r_timeout;
  logic        r_perr;

  logic       w_stall;
  logic       w_illegal;
  logic [7:0] w_run_next;

  // A flush ignores the handshake entirely, so neither a stall nor an
  // illegal combination is recognised on a flush edge.
  assign w_stall    = !i_branch_taken && !(i_pc_write && i_if_id_write);
  assign w_illegal  = !i_branch_taken && i_pc_write && !i_if_id_write;
  assign w_run_next = (r_run == RUN_MAX) ? r_run : r_run + 8'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_count <= '0;
      r_run         <= '0;
      r_timeout     <= 1'b0;
      r_perr        <= 1'b0;
    end else begin
      if (w_stall) begin
        if (r_stall_count != 32'hFFFF_FFFF) r_stall_count <= r_stall_count + 32'd1;
        r_run <= w_run_next;
        if (w_run_next == RUN_MAX) r_timeout <= 1'b1;
      end else begin
        r_run <= '0;
      end
      if (w_illegal) r_perr <= 1'b1;
    end
  end

  assign o_stall_count    = r_stall_count;
  assign o_stall_timeout  = r_timeout;
  assign o_protocol_error = r_perr;

endmodule

// File: rtl/fetch_stall_stage.sv
// LEGv8 fetch stage with IF/ID pipeline register.
//   clk, reset          - clock and asynchronous active-high reset
//   PCWrite/IF_ID_Write - load-use stall handshake from the hazard unit
//   Branch_Taken/Target - redirect and flush from EX/MEM
//   Instruction         - asynchronous imem read data for imem_addr
//   imem_addr           - current PC (combinational from the PC register)
//   IF_ID_PC/Instruction/Valid - IF/ID pipeline register
//   stall_count, stall_timeout, protocol_error - stall bookkeeping
module fetch_stall_stage
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
  parameter int          MAX_STALL = 8,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  input  logic [31:0] Instruction,
  output logic [63:0] imem_addr,
  output logic [63:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid,
  output logic [31:0] stall_count,
  output logic        stall_timeout,
  output logic        protocol_error
);

  logic [63:0]  r_pc;
  logic [63:0]  r_if_id_pc;
  logic [31:0]  r_if_id_instr;
  logic         r_if_id_valid;
  fetch_state_e r_state;

  logic w_advance;
  logic w_split;
  logic w_unused_state;

  assign w_advance = !Branch_Taken && PCWrite && IF_ID_Write;
  // PC held but IF/ID told to load: insert a bubble instead of latching the
  // same instruction a second time.
  assign w_split   = !Branch_Taken && !PCWrite && IF_ID_Write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_state       <= FILL;
    end else begin
      r_state <= fetch_next_state(r_state, Branch_Taken, w_advance);
      if (Branch_Taken || w_split) begin
        r_if_id_pc    <= '0;
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
      end else if (w_advance) begin
        r_if_id_pc    <= r_pc;
        r_if_id_instr <= Instruction;
        r_if_id_valid <= 1'b1;
      end
      if (Branch_Taken)   r_pc <= Branch_Target;
      else if (w_advance) r_pc <= r_pc + PC_INC;
    end
  end

  // The state is tracked for debug visibility; every output it would
  // imply is already carried by the IF/ID register and the counters.
  assign w_unused_state = ^r_state;

  stall_monitor #(
    .MAX_STALL(MAX_STALL)
  ) u_stall_monitor (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_pc_write       (PCWrite),
    .i_if_id_write    (IF_ID_Write),
    .i_branch_taken   (Branch_Taken),
    .o_stall_count    (stall_count),
    .o_stall_timeout  (stall_timeout),
    .o_protocol_error (protocol_error)
  );

  assign imem_addr         = r_pc;
  assign IF_ID_PC          = r_if_id_pc;
  assign IF_ID_Instruction = r_if_id_instr;
  assign IF_ID_Valid       = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stall_stage.sv
module tb_fetch_stall_stage;

  localparam int          MAXS = 8;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADD  = 32'h8B02_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IF_ID_Write, Branch_Taken;
  logic [63:0] Branch_Target;
  logic [31:0] Instruction;
  logic [63:0] imem_addr, IF_ID_PC;
  logic [31:0] IF_ID_Instruction, stall_count;
  logic        IF_ID_Valid, stall_timeout, protocol_error;

  fetch_stall_stage #(
    .RESET_PC (64'h0),
    .MAX_STALL(MAXS),
    .NOP_INSTR(NOP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .Branch_Taken     (Branch_Taken),
    .Branch_Target    (Branch_Target),
    .Instruction      (Instruction),
    .imem_addr        (imem_addr),
    .IF_ID_PC         (IF_ID_PC),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_Valid      (IF_ID_Valid),
    .stall_count      (stall_count),
    .stall_timeout    (stall_timeout),
    .protocol_error   (protocol_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Snapshot layout: {pc, if_id_pc, instr, valid, stall_count, timeout, perr}
  logic [194:0] exp_q[$];
  logic [194:0] exp_v, act_v;

  // Reference model state
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ins, m_cnt;
  logic        m_val, m_to, m_perr;
  int          m_run;

  function automatic logic [194:0] snap_dut();
    return {imem_addr, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
            stall_count, stall_timeout, protocol_error};
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_ifpc = 64'h0; m_ins = NOP; m_val = 1'b0;
    m_cnt = 32'h0; m_run = 0; m_to = 1'b0; m_perr = 1'b0;
  endtask

  task automatic push_model();
    exp_q.push_back({m_pc, m_ifpc, m_ins, m_val, m_cnt, m_to, m_perr});
  endtask

  // Drive one cycle, update the model, push the expectation, clock it.
  task automatic step(input logic pcw, input logic ifw, input logic br,
                      input logic [63:0] tgt, input logic [31:0] ins);
    PCWrite = pcw; IF_ID_Write = ifw; Branch_Taken = br;
    Branch_Target = tgt; Instruction = ins;
    if (br) begin
      m_pc = tgt; m_ifpc = 64'h0; m_ins = NOP; m_val = 1'b0; m_run = 0;
    end else if (pcw && ifw) begin
      m_ifpc = m_pc; m_ins = ins; m_val = 1'b1;
      m_pc = m_pc + 64'd4; m_run = 0;
    end else begin
      if (!pcw && ifw) begin
        m_ifpc = 64'h0; m_ins = NOP; m_val = 1'b0;
      end
      if (pcw && !ifw) m_perr = 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_run < MAXS) m_run = m_run + 1;
      if (m_run == MAXS) m_to = 1'b1;
    end
    push_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    PCWrite = 1'b0; IF_ID_Write = 1'b0; Branch_Taken = 1'b0;
    Branch_Target = '0; Instruction = '0;
    #2;
    model_reset();
    push_model();
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL reset_state act=%h exp=%h", act_v, exp_v);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset released: imem_addr=%h", imem_addr);
  endtask

  task automatic test_advance();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, '0, ADD);
      exp_v = exp_q.pop_front(); act_v = snap_dut();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL advance_%0d act=%h exp=%h", i, act_v, exp_v);
      end
      checks++;
      if (imem_addr !== 64'(4 * (i + 1))) begin
        errors++; $display("FAIL advance_addr_%0d act=%h exp=%h", i, imem_addr, 64'(4 * (i + 1)));
      end
      if (i == 0) begin
        checks++;
        if (IF_ID_PC !== 64'h0 || IF_ID_Valid !== 1'b1) begin
          errors++; $display("FAIL first_ifid act=%h/%b exp=0/1", IF_ID_PC, IF_ID_Valid);
        end
      end
      $display("advance %0d: pc=%h ifid_pc=%h", i, imem_addr, IF_ID_PC);
    end
  endtask

  task automatic test_single_stall();
    step(0, 0, 0, '0, 32'hDEAD_BEEF);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL single_stall act=%h exp=%h", act_v, exp_v);
    end
    checks++;
    if (imem_addr !== 64'h8 || stall_count !== 32'd1 || IF_ID_Instruction !== ADD) begin
      errors++; $display("FAIL single_stall_const act=%h/%0d/%h exp=8/1/%h",
                         imem_addr, stall_count, IF_ID_Instruction, ADD);
    end
    step(1, 1, 0, '0, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v || imem_addr !== 64'hC) begin
      errors++; $display("FAIL stall_resume act=%h exp=%h", act_v, exp_v);
    end
    $display("single stall: pc=%h stall_count=%0d", imem_addr, stall_count);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 64 && m_pc != 64'h40; i++) begin
      step(1, 1, 0, '0, 32'(i) ^ ADD);
      exp_v = exp_q.pop_front(); act_v = snap_dut();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL walk_%0d act=%h exp=%h", i, act_v, exp_v);
      end
    end
    step(0, 0, 1, 64'h100, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL flush act=%h exp=%h", act_v, exp_v);
    end
    checks++;
    if (imem_addr !== 64'h100 || IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== NOP) begin
      errors++; $display("FAIL flush_const act=%h/%b/%h exp=100/0/%h",
                         imem_addr, IF_ID_Valid, IF_ID_Instruction, NOP);
    end
    $display("flush: pc=%h valid=%b", imem_addr, IF_ID_Valid);
  endtask

  task automatic test_timeout();
    do_reset();
    step(1, 1, 0, '0, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL to_pre act=%h exp=%h", act_v, exp_v);
    end
    for (int i = 1; i <= MAXS; i++) begin
      step(0, 0, 0, '0, ADD);
      exp_v = exp_q.pop_front(); act_v = snap_dut();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL to_stall_%0d act=%h exp=%h", i, act_v, exp_v);
      end
      checks++;
      if (stall_timeout !== (i == MAXS)) begin
        errors++; $display("FAIL to_edge_%0d act=%b exp=%b", i, stall_timeout, (i == MAXS));
      end
    end
    checks++;
    if (stall_count !== 32'd8) begin
      errors++; $display("FAIL to_count act=%0d exp=8", stall_count);
    end
    step(1, 1, 0, '0, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v || stall_timeout !== 1'b1) begin
      errors++; $display("FAIL to_sticky act=%h exp=%h", act_v, exp_v);
    end
    $display("timeout: stall_count=%0d timeout=%b", stall_count, stall_timeout);
  endtask

  task automatic test_split_illegal();
    do_reset();
    while (m_pc != 64'h20) begin
      step(1, 1, 0, '0, ADD);
      exp_v = exp_q.pop_front(); act_v = snap_dut();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL split_walk act=%h exp=%h", act_v, exp_v);
      end
    end
    step(0, 1, 0, '0, 32'h1111_2222);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v || imem_addr !== 64'h20 || IF_ID_Valid !== 1'b0) begin
      errors++; $display("FAIL split act=%h exp=%h", act_v, exp_v);
    end
    step(1, 0, 0, '0, 32'h3333_4444);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v || protocol_error !== 1'b1 || imem_addr !== 64'h20) begin
      errors++; $display("FAIL illegal act=%h exp=%h", act_v, exp_v);
    end
    $display("split/illegal: pc=%h perr=%b count=%0d", imem_addr, protocol_error, stall_count);
  endtask

  task automatic test_back_to_back();
    // Stall then flush: redirect wins, held instruction discarded.
    step(1, 1, 0, '0, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL b2b_adv act=%h exp=%h", act_v, exp_v);
    end
    step(0, 0, 0, '0, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL b2b_stall act=%h exp=%h", act_v, exp_v);
    end
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL b2b_flush act=%h exp=%h", act_v, exp_v);
    end
    step(1, 1, 0, '0, 32'hCAFE_F00D);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v || imem_addr !== 64'h0 || IF_ID_PC !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap act=%h exp=%h", act_v, exp_v);
    end
    $display("wrap: pc=%h ifid_pc=%h", imem_addr, IF_ID_PC);
  endtask

  task automatic test_reset_mid_stall();
    step(0, 0, 0, '0, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL pre_rst_stall act=%h exp=%h", act_v, exp_v);
    end
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    reset = 1'b1;
    #2;
    model_reset();
    push_model();
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL async_reset act=%h exp=%h", act_v, exp_v);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 1, 0, '0, ADD);
    exp_v = exp_q.pop_front(); act_v = snap_dut();
    checks++;
    if (act_v !== exp_v || IF_ID_PC !== 64'h0 || imem_addr !== 64'h4) begin
      errors++; $display("FAIL post_reset_fetch act=%h exp=%h", act_v, exp_v);
    end
    $display("reset mid-stall: pc=%h valid=%b", imem_addr, IF_ID_Valid);
  endtask

  initial begin
    test_reset();
    test_advance();
    test_single_stall();
    test_flush();
    test_timeout();
    test_split_illegal();
    test_back_to_back();
    test_reset_mid_stall();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain act=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stall_stage.md
Name: fetch_stall_stage

Overview:
- Fetch stage and IF/ID pipeline register for the LEGv8 five-stage pipeline.
- Consumes the load-use stall handshake (PCWrite, IF_ID_Write) and the branch flush from EX/MEM.
- Owns the PC register, PC+4 sequencing, branch redirect, bubble insertion into IF/ID, and stall bookkeeping (saturating stall counter, stall-timeout watchdog, protocol-error flag).

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- MAX_STALL, 8, consecutive stall cycles that trip stall_timeout (legal range 1..255).
- NOP_INSTR, 32'h00000000, instruction word placed in IF/ID for a bubble.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- PCWrite  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
- IF_ID_Write  input  1  1 = IF/ID may load; 0 = hold IF/ID.
- Branch_Taken  input  1  redirect and flush request.
- Branch_Target  input  64  redirect PC.
- Instruction  input  32  instruction memory read data for imem_addr, same cycle (asynchronous read).
- imem_addr  output  64  current PC, driven combinationally from the PC register.
- IF_ID_PC  output  64  registered PC of the instruction held in IF/ID.
- IF_ID_Instruction  output  32  registered instruction word.
- IF_ID_Valid  output  1  0 = IF/ID holds a bubble.
- stall_count  output  32  saturating count of stall cycles since reset.
- stall_timeout  output  1  sticky; set when the consecutive stall run reaches MAX_STALL.
- protocol_error  output  1  sticky; set on PCWrite=1 with IF_ID_Write=0.

Behaviour:
- Reset (asynchronous, immediate): PC=RESET_PC, IF_ID_PC=0, IF_ID_Instruction=NOP_INSTR, IF_ID_Valid=0, stall_count=0, run counter=0, stall_timeout=0, protocol_error=0, state=FILL.
- Per-edge priority is flush > stall > advance.
- Flush (Branch_Taken=1):
  - PC <= Branch_Target; IF/ID <= bubble (PC 0, NOP_INSTR, Valid 0).
  - PCWrite and IF_ID_Write are ignored; the run counter clears.
- Advance (PCWrite=1, IF_ID_Write=1):
  - PC <= PC+4, modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
  - IF/ID <= {PC, Instruction, Valid=1}.
- Stall (PCWrite=0, IF_ID_Write=0):
  - PC and IF/ID hold.
  - stall_count increments, saturating at 32'hFFFFFFFF.
  - Run counter increments, saturating at MAX_STALL.
- Split (PCWrite=0, IF_ID_Write=1):
  - PC holds; IF/ID <= bubble, so no instruction is duplicated.
  - Counted as a stall cycle.
- Illegal (PCWrite=1, IF_ID_Write=0):
  - Treated as a full stall; protocol_error <= 1.
- stall_timeout <= 1 on the edge where the run counter becomes MAX_STALL. Cleared only by reset.
- The run counter clears on any advance or flush edge.
- State machine (observable through IF_ID_Valid and the counters):
  - FILL: first cycle after reset. IF_ID_Valid=0. Goes to RUN on advance, FLUSHED on flush, and stays in FILL on stall.
  - RUN: goes to STALL on stall/split/illegal, FLUSHED on flush, and stays in RUN on advance.
  - STALL: goes to RUN on advance, FLUSHED on flush, and stays in STALL otherwise.
  - FLUSHED: IF/ID holds a bubble. Goes to RUN on advance, STALL on stall, and stays in FLUSHED on flush.
- Flush while in STALL: the redirect wins, the held instruction is discarded, and the stall ends.
- Reset asserted mid-stall or mid-flush: all state returns to reset values immediately. The first edge after release fetches RESET_PC.
- imem_addr always equals the PC register and has no extra latency. Fetch-to-IF/ID latency is 1 cycle.

Decomposition:
- Shared package `legv8_pkg`:
  - NOP_INSTR and RESET_PC defaults.
  - PC_INC = 64'd4.
  - Fetch state enum: FILL, RUN, STALL, FLUSHED.
- One natural sub-module, `stall_monitor`: owns stall_count, the run counter, stall_timeout and protocol_error. Inputs are PCWrite, IF_ID_Write, Branch_Taken, clk and reset.

Test Plan:
- Reset release, PCWrite=IF_ID_Write=1, Instruction=32'h8B020020 -> imem_addr 0,4,8 on successive cycles; IF_ID_PC=0 and IF_ID_Valid=1 after the first edge.
- At PC=8, PCWrite=IF_ID_Write=0 for 1 cycle -> PC stays 8, IF/ID unchanged, stall_count=1; next edge PC=12.
- At PC=0x40, Branch_Taken=1 with Branch_Target=0x100 while PCWrite=0 -> PC=0x100, IF_ID_Valid=0, IF_ID_Instruction=NOP_INSTR, run counter 0.
- MAX_STALL=8, hold PCWrite=IF_ID_Write=0 for 8 cycles:
  - stall_timeout rises on the 8th edge and stays 1 after the pipeline resumes.
  - stall_count=8.
- Split case PCWrite=0, IF_ID_Write=1 at PC=0x20 -> PC holds 0x20, IF_ID_Valid=0; then PCWrite=1 with IF_ID_Write=0 -> protocol_error=1 and PC still 0x20.
- PC=64'hFFFF_FFFF_FFFF_FFFC advancing -> PC wraps to 0; assert reset mid-stall -> all outputs at reset values before the next clk edge.
